// File: rtl/mem_sequencer_if.sv
// Bus bundle for mem_sequencer: CPU fetch and data ports, external loader/debug port, SRAM port.
// master is the sequencer side; slave is the CPU/loader/SRAM environment side.
interface mem_sequencer_if #(
    parameter int unsigned AW = 12
);
    logic [31:0]   cpu_rom_addr;
    logic [31:0]   cpu_rom_rdata;
    logic          cpu_rom_rdy;
    logic [31:0]   cpu_mem_addr;
    logic [31:0]   cpu_mem_wdata;
    logic          cpu_mem_we;
    logic [31:0]   cpu_mem_rdata;

    logic          ext_req;
    logic          ext_we;
    logic [31:0]   ext_addr;
    logic [31:0]   ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [31:0]   ext_rdata;

    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    modport master (
        input  cpu_rom_addr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_we,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  sram_rdata,
        output cpu_rom_rdata, cpu_rom_rdy, cpu_mem_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        output cpu_rom_addr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_we,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output sram_rdata,
        input  cpu_rom_rdata, cpu_rom_rdy, cpu_mem_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_sequencer.sv
// Shares one single-port synchronous SRAM between CPU fetch, CPU data and an external port.
// Each CPU instruction is framed fetch -> data access -> commit; ext accesses slot in at commit.
module mem_sequencer #(
    parameter int unsigned AW        = 12,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned EXT_BURST = 1,
    parameter logic [31:0] RST_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    mem_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_I_ISS,
        S_I_WAIT,
        S_D_SET,
        S_D_ISS,
        S_D_WAIT,
        S_COMMIT,
        S_X_ISS,
        S_X_WAIT
    } state_e;

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);
    localparam logic [3:0] BURST_MAX = 4'(EXT_BURST);

    state_e        state_q;
    logic [1:0]    wait_q;
    logic [3:0]    ext_cnt_q;

    logic [31:0]   rom_rdata_q;
    logic          rom_rdy_q;
    logic [31:0]   mem_rdata_q;
    logic          ext_gnt_q;
    logic          ext_rvalid_q;
    logic [31:0]   ext_rdata_q;
    logic          sram_en_q;
    logic          sram_we_q;
    logic [AW-1:0] sram_addr_q;
    logic [31:0]   sram_wdata_q;

    logic [AW-1:0] rom_word;
    logic [AW-1:0] mem_word;
    logic [AW-1:0] ext_word;
    logic [3:0]    ext_cnt_base;
    logic          ext_go;
    logic          unused_addr_bits;

    // Word addressing drops the byte offset and everything above the SRAM, so addresses wrap.
    assign rom_word = bus.cpu_rom_addr[AW+1:2];
    assign mem_word = bus.cpu_mem_addr[AW+1:2];
    assign ext_word = bus.ext_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.cpu_rom_addr, bus.cpu_mem_addr, bus.ext_addr};

    // A commit restarts the ext burst allowance, so the decision taken in COMMIT sees zero.
    always_comb begin
        ext_cnt_base = (state_q == S_COMMIT) ? 4'd0 : ext_cnt_q;
        ext_go       = bus.ext_req && (ext_cnt_base < BURST_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register in this
    // block samples the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            ext_cnt_q    <= '0;
            rom_rdata_q  <= RST_INSTR;
            rom_rdy_q    <= 1'b0;
            mem_rdata_q  <= '0;
            ext_gnt_q    <= 1'b0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            // NOTE: strobes default low each cycle so they can only ever be one-cycle pulses.
            rom_rdy_q    <= 1'b0;
            ext_gnt_q    <= 1'b0;
            ext_rvalid_q <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;

            unique case (state_q)
                S_IDLE, S_COMMIT: begin
                    if (ext_go) begin
                        state_q      <= S_X_ISS;
                        ext_cnt_q    <= ext_cnt_base + 4'd1;
                        ext_gnt_q    <= 1'b1;
                        sram_en_q    <= 1'b1;
                        sram_we_q    <= bus.ext_we;
                        sram_addr_q  <= ext_word;
                        sram_wdata_q <= bus.ext_wdata;
                    end else begin
                        state_q      <= S_I_ISS;
                        ext_cnt_q    <= ext_cnt_base;
                        sram_en_q    <= 1'b1;
                        sram_addr_q  <= rom_word;
                    end
                end

                S_I_ISS: begin
                    state_q <= S_I_WAIT;
                    wait_q  <= WAIT_LOAD;
                end

                S_I_WAIT: begin
                    if (wait_q == 2'd0) begin
                        rom_rdata_q <= bus.sram_rdata;
                        state_q     <= S_D_SET;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end

                // The CPU decodes the fresh instruction during D_SET; its data request is
                // captured straight into the SRAM command registers at the end of the cycle.
                S_D_SET: begin
                    state_q      <= S_D_ISS;
                    sram_en_q    <= 1'b1;
                    sram_we_q    <= bus.cpu_mem_we;
                    sram_addr_q  <= mem_word;
                    sram_wdata_q <= bus.cpu_mem_wdata;
                end

                S_D_ISS: begin
                    if (sram_we_q) begin
                        state_q   <= S_COMMIT;
                        rom_rdy_q <= 1'b1;
                    end else begin
                        state_q <= S_D_WAIT;
                        wait_q  <= WAIT_LOAD;
                    end
                end

                S_D_WAIT: begin
                    if (wait_q == 2'd0) begin
                        mem_rdata_q <= bus.sram_rdata;
                        state_q     <= S_COMMIT;
                        rom_rdy_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end

                // Ext accesses return through IDLE, which re-runs the boundary decision
                // without a commit pulse and without clearing the burst count.
                S_X_ISS: begin
                    if (sram_we_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_X_WAIT;
                        wait_q  <= WAIT_LOAD;
                    end
                end

                S_X_WAIT: begin
                    if (wait_q == 2'd0) begin
                        ext_rdata_q  <= bus.sram_rdata;
                        ext_rvalid_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_rom_rdata = rom_rdata_q;
    assign bus.cpu_rom_rdy   = rom_rdy_q;
    assign bus.cpu_mem_rdata = mem_rdata_q;
    assign bus.ext_gnt       = ext_gnt_q;
    assign bus.ext_rvalid    = ext_rvalid_q;
    assign bus.ext_rdata     = ext_rdata_q;
    assign bus.sram_en       = sram_en_q;
    assign bus.sram_we       = sram_we_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_wdata    = sram_wdata_q;

endmodule
